n64_poll_transmitter: RTL and testbench

// Console-side initiator for the N64 controller one-wire bus. Serialises the 8-bit poll

---
 rtl/n64_poll_transmitter.sv | 154 +++++++++++++++
 tb/tb_n64_poll_transmitter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/n64_poll_transmitter.sv
// Console-side N64 one-wire poll initiator: serialises CMD plus a stop bit with
// pulse-width coding, then releases the bus and arms the reply receiver.
module n64_poll_transmitter #(
  parameter int         CLKS_PER_US    = 12,
  parameter logic [7:0] CMD            = 8'h01,
  parameter int         POLL_PERIOD_US = 16667,
  parameter int         RX_WINDOW_US   = 160
) (
  input  logic clock,
  input  logic reset_n,
  input  logic auto_en,
  input  logic start,
  output logic line_oe,
  output logic enable_latch,
  output logic busy
);

  localparam int U             = CLKS_PER_US;
  localparam int PH_W          = $clog2(3 * U);
  localparam int PERIOD_CYCLES = POLL_PERIOD_US * U;
  localparam int PER_W         = $clog2(PERIOD_CYCLES + 1);
  localparam int RX_CYCLES     = RX_WINDOW_US * U;
  localparam int RX_W          = $clog2(RX_CYCLES + 1);

  localparam logic [PH_W-1:0]  SHORT_LAST  = PH_W'(U - 1);
  localparam logic [PH_W-1:0]  LONG_LAST   = PH_W'(3 * U - 1);
  localparam logic [PER_W-1:0] PERIOD_LAST = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [RX_W-1:0]  RX_LAST     = RX_W'(RX_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BIT_LO  = 3'd1,
    BIT_HI  = 3'd2,
    STOP_LO = 3'd3,
    RX_WAIT = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [PH_W-1:0]   phase_cnt, phase_next;
  logic [2:0]        bit_idx, bit_next;
  logic [RX_W-1:0]   rx_cnt, rx_next;
  logic [PER_W-1:0]  period_cnt, period_next;
  logic              line_oe_next, enable_latch_next, busy_next;
  logic              trigger;
  logic              cur_bit;
  logic [PH_W-1:0]   lo_last, hi_last;

  assign cur_bit = CMD[3'd7 - bit_idx];
  // A '1' is a short low then a long high; a '0' is the reverse.
  assign lo_last = cur_bit ? SHORT_LAST : LONG_LAST;
  assign hi_last = cur_bit ? LONG_LAST  : SHORT_LAST;
  assign trigger = start | (auto_en & (period_cnt == PERIOD_LAST));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      phase_cnt    <= '0;
      bit_idx      <= '0;
      rx_cnt       <= '0;
      period_cnt   <= '0;
      line_oe      <= 1'b0;
      enable_latch <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      phase_cnt    <= phase_next;
      bit_idx      <= bit_next;
      rx_cnt       <= rx_next;
      period_cnt   <= period_next;
      line_oe      <= line_oe_next;
      enable_latch <= enable_latch_next;
      busy         <= busy_next;
    end
  end

  always_comb begin
    state_next  = state;
    phase_next  = phase_cnt;
    bit_next    = bit_idx;
    rx_next     = rx_cnt;
    unique case (state)
      IDLE: begin
        if (trigger) begin
          state_next = BIT_LO;
          phase_next = '0;
          bit_next   = '0;
        end
      end
      BIT_LO: begin
        if (phase_cnt == lo_last) begin
          state_next = BIT_HI;
          phase_next = '0;
        end else begin
          phase_next = phase_cnt + PH_W'(1);
        end
      end
      BIT_HI: begin
        if (phase_cnt == hi_last) begin
          phase_next = '0;
          if (bit_idx == 3'd7) begin
            state_next = STOP_LO;
            bit_next   = '0;
          end else begin
            state_next = BIT_LO;
            bit_next   = bit_idx + 3'd1;
          end
        end else begin
          phase_next = phase_cnt + PH_W'(1);
        end
      end
      STOP_LO: begin
        if (phase_cnt == SHORT_LAST) begin
          state_next = RX_WAIT;
          phase_next = '0;
          rx_next    = '0;
        end else begin
          phase_next = phase_cnt + PH_W'(1);
        end
      end
      RX_WAIT: begin
        if (rx_cnt == RX_LAST) begin
          state_next = IDLE;
          rx_next    = '0;
        end else begin
          rx_next = rx_cnt + RX_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
        bit_next   = '0;
        rx_next    = '0;
      end
    endcase
  end

  // Period counter saturates so an expiry during a frame fires on the first IDLE cycle.
  always_comb begin
    period_next = period_cnt;
    if (!auto_en || (state == IDLE && trigger)) begin
      period_next = '0;
    end else if (period_cnt != PERIOD_LAST) begin
      period_next = period_cnt + PER_W'(1);
    end
  end

  // Outputs are registered from the next state so the bus driver never glitches.
  always_comb begin
    line_oe_next      = (state_next == BIT_LO) || (state_next == STOP_LO);
    busy_next         = (state_next != IDLE);
    enable_latch_next = (state == STOP_LO) && (state_next == RX_WAIT);
  end

endmodule

// File: tb/tb_n64_poll_transmitter.sv
// Directed bench for n64_poll_transmitter: frame timing tables, bit decoding,
// auto-poll period, async reset abort and loopback arming of the receiver.
module tb_n64_poll_transmitter;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic auto_en = 1'b0;
  logic start_c = 1'b0;
  logic auto_a  = 1'b0;
  logic start_a = 1'b0;
  logic line_oe, enable_latch, busy;
  logic line_oe_a, enable_latch_a, busy_a;
  logic rx_data;

  always #5 clock = ~clock;

  n64_poll_transmitter #(.CLKS_PER_US(4), .CMD(8'h01), .POLL_PERIOD_US(100), .RX_WINDOW_US(10)) dut (
    .clock(clock), .reset_n(reset_n), .auto_en(auto_en), .start(start_c),
    .line_oe(line_oe), .enable_latch(enable_latch), .busy(busy)
  );

  n64_poll_transmitter #(.CLKS_PER_US(4), .CMD(8'hA5), .POLL_PERIOD_US(100), .RX_WINDOW_US(10)) dut_a5 (
    .clock(clock), .reset_n(reset_n), .auto_en(auto_a), .start(start_a),
    .line_oe(line_oe_a), .enable_latch(enable_latch_a), .busy(busy_a)
  );

  // Open-drain loopback: receiver sees the inverted drive.
  assign rx_data = ~line_oe;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rises[$];
  int el_count = 0;
  int rx_armed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycle monitor: samples 1 time unit after each edge; test code samples at 2.
  initial begin
    int last_rise;
    logic prev_busy;
    last_rise = -1;
    prev_busy = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (!reset_n) begin
        last_rise = -1;
        prev_busy = 1'b0;
        chk("reset_quiet", {29'd0, line_oe, busy, enable_latch}, 0);
      end else begin
        if (busy && !prev_busy) begin
          rises.push_back(cyc);
          last_rise = cyc;
        end
        if (!busy && prev_busy && last_rise >= 0)
          chk("busy_len", cyc - last_rise, 172);
        if (enable_latch) begin
          el_count++;
          rx_armed = 1;
          chk("el_pos", cyc - last_rise, 132);
          chk("el_rx_idle_high", int'(rx_data), 1);
        end
        prev_busy = busy;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  logic oe_c[200], busy_c[200], el_c[200];
  logic oe_a[200], busy_a_c[200], el_a[200];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      oe_c[i] = line_oe;   busy_c[i]   = busy;   el_c[i] = enable_latch;
      oe_a[i] = line_oe_a; busy_a_c[i] = busy_a; el_a[i] = enable_latch_a;
    end
  endtask

  typedef struct {
    int   cyc;
    logic oe;
    logic bsy;
    logic el;
  } vec_t;
  vec_t tbl[16];

  task automatic check_table(input string pfx);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s_oe@%0d", pfx, tbl[k].cyc), int'(oe_c[tbl[k].cyc]), int'(tbl[k].oe));
      chk($sformatf("%s_busy@%0d", pfx, tbl[k].cyc), int'(busy_c[tbl[k].cyc]), int'(tbl[k].bsy));
      chk($sformatf("%s_el@%0d", pfx, tbl[k].cyc), int'(el_c[tbl[k].cyc]), int'(tbl[k].el));
    end
  endtask

  int lo_r[16], hi_r[16];
  int nl, nh;

  task automatic analyze(input int sel);
    logic cur, v;
    int len;
    nl = 0; nh = 0;
    cur = sel ? oe_a[0] : oe_c[0];
    len = 0;
    for (int i = 0; i < 172; i++) begin
      v = sel ? oe_a[i] : oe_c[i];
      if (v == cur) len++;
      else begin
        if (cur) begin if (nl < 16) lo_r[nl] = len; nl++; end
        else begin if (nh < 16) hi_r[nh] = len; nh++; end
        cur = v;
        len = 1;
      end
    end
    if (cur) begin if (nl < 16) lo_r[nl] = len; nl++; end
    else begin if (nh < 16) hi_r[nh] = len; nh++; end
  endtask

  int exp_lo01[9] = '{12, 12, 12, 12, 12, 12, 12, 4, 4};
  int exp_hi01[9] = '{4, 4, 4, 4, 4, 4, 4, 12, 40};
  int exp_loa5[9] = '{4, 12, 4, 12, 12, 4, 12, 4, 4};
  int exp_hia5[9] = '{12, 4, 12, 4, 4, 12, 4, 12, 40};

  initial begin
    int e, r, el0, decoded, bit_time;

    tbl[0]  = '{0,   1'b1, 1'b1, 1'b0};
    tbl[1]  = '{11,  1'b1, 1'b1, 1'b0};
    tbl[2]  = '{12,  1'b0, 1'b1, 1'b0};
    tbl[3]  = '{15,  1'b0, 1'b1, 1'b0};
    tbl[4]  = '{16,  1'b1, 1'b1, 1'b0};
    tbl[5]  = '{111, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{112, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{115, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{116, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{127, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{128, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{131, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{132, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{133, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{171, 0,    1'b1, 1'b0};
    tbl[15] = '{172, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) step();
    chk("rst_line_oe", int'(line_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_el", int'(enable_latch), 0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("idle_busy", int'(busy), 0);

    // Frames for CMD=0x01 and CMD=0xA5 started together
    start_c = 1'b1; start_a = 1'b1;
    step();
    start_c = 1'b0; start_a = 1'b0;
    capture(180);
    check_table("f01");
    analyze(0);
    chk("f01_nlow", nl, 9);
    chk("f01_nhigh", nh, 9);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("f01_low%0d", k), lo_r[k], exp_lo01[k]);
      chk($sformatf("f01_high%0d", k), hi_r[k], exp_hi01[k]);
    end
    chk("f01_armed", rx_armed, 1);
    rx_armed = 0;

    analyze(1);
    chk("a5_nlow", nl, 9);
    decoded = 0;
    bit_time = 0;
    for (int k = 0; k < 8; k++) begin
      decoded = (decoded << 1) | ((lo_r[k] == 4) ? 1 : 0);
      bit_time += lo_r[k] + hi_r[k];
    end
    chk("a5_decoded", decoded, 8'hA5);
    chk("a5_bit_time", bit_time, 128);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("a5_low%0d", k), lo_r[k], exp_loa5[k]);
      chk($sformatf("a5_high%0d", k), hi_r[k], exp_hia5[k]);
    end
    chk("a5_el@132", int'(el_a[132]), 1);
    chk("a5_el@131", int'(el_a[131]), 0);
    chk("a5_busy@171", int'(busy_a_c[171]), 1);
    chk("a5_busy@172", int'(busy_a_c[172]), 0);

    // Async reset in the low phase of bit 3
    el0 = el_count;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    repeat (50) step();
    chk("abort_pre_oe", int'(line_oe), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_oe", int'(line_oe), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_el", int'(enable_latch), 0);
    repeat (3) step();
    reset_n = 1'b1;
    repeat (2) step();
    chk("abort_no_el", el_count, el0);
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    capture(180);
    check_table("post_rst");
    chk("post_rst_el", el_count, el0 + 1);

    // Auto polling every 400 cycles; start during busy is ignored
    rises.delete();
    e = cyc;
    auto_en = 1'b1;
    while (cyc < e + 420) step();
    start_c = 1'b1; step(); start_c = 1'b0;
    while (cyc < e + 550) step();
    start_c = 1'b1; step(); start_c = 1'b0;
    chk("rx_wait_oe", int'(line_oe), 0);
    chk("rx_wait_busy", int'(busy), 1);
    while (rises.size() < 3 && cyc < e + 1300) step();
    chk("auto_frames", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("auto_first", rises[0] - e, 400);
      chk("auto_gap1", rises[1] - rises[0], 400);
      chk("auto_gap2", rises[2] - rises[1], 400);
    end

    // start coincides with period expiry, then auto_en dropped mid-frame
    r = (rises.size() >= 3) ? rises[2] : cyc;
    while (cyc < r + 399) step();
    start_c = 1'b1; step(); start_c = 1'b0;
    while (cyc < r + 850) step();
    auto_en = 1'b0;
    while (cyc < r + 1300) step();
    chk("coincide_frames", rises.size(), 5);
    if (rises.size() >= 5) begin
      chk("coincide_at", rises[3] - r, 400);
      chk("coincide_next", rises[4] - rises[3], 400);
    end
    chk("total_el", el_count, 7);
    chk("loop_armed", rx_armed, 1);
    chk("final_busy", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
